// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble) with valid/ready input handshake.
// Optional leading-zero blank mask is compiled in when BCD_BLANK_EN is defined.
`timescale 1ns / 1ps

module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clk_5MHz,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BcdW = 4 * DIGITS;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam longint unsigned MaxIn = (64'd1 << WIDTH) - 64'd1;

  if (pow10(DIGITS) <= MaxIn) begin : g_digits_chk
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end
  if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_cnt_chk
    $error("bin_to_bcd_seq: CNT_W too small for WIDTH");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              out_valid_q, out_valid_d;
  logic [BcdW-1:0]   adj;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    out_valid_d = 1'b0;
    adj         = scratch_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d     = in_data;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = StShift;
        end
      end
      StShift: begin
        // Add-3 is per digit; no carry may ripple into the next digit.
        for (int unsigned k = 0; k < DIGITS; k++) begin
          if (scratch_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
          end
        end
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d              = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d       = scratch_q;
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] mask;
  logic              nz;

  // Scan from the top digit down; a digit blanks only while everything above it is zero too.
  always_comb begin
    mask = '0;
    nz   = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      nz      = nz | (|scratch_q[4*k +: 4]);
      mask[k] = ~nz;
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (state_q == StDone) begin
      blank_d = mask;
    end
  end

  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

  assign in_ready  = (state_q == StIdle);
  assign busy      = ~in_ready;
  assign bcd_out   = bcd_q;
  assign out_valid = out_valid_q;

endmodule
